// File: rtl/cluster_mem_responder.sv
// Memory responder for a hart cluster: fetches/loads a 4-beat cache line or
// performs one sub-word store on a simple beat-level backend with ack handshake.
module cluster_mem_responder #(
  parameter int LINE_BEATS  = 4,
  parameter int MEM_LAT_MAX = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_req,
  input  logic [2:0]   i_mode,
  input  logic [31:0]  i_iaddr,
  input  logic [31:0]  i_daddr,
  input  logic [31:0]  i_wdata,
  input  logic [2:0]   i_ctrl,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [127:0] o_insn_data,
  output logic [127:0] o_data_data,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [31:0]  o_mem_addr,
  output logic [31:0]  o_mem_wdata,
  output logic [3:0]   o_mem_wstrb,
  input  logic         i_mem_ack,
  input  logic [31:0]  i_mem_rdata,
  output logic [2:0]   o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Backend handshake: a beat is presented with o_mem_req=1 and held unchanged
  // until the cycle i_mem_ack=1; that cycle transfers the beat (read data included).
  state_t      r_state;
  state_t      w_next;
  logic        r_fetch;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_ctrl;
  logic [1:0]  r_beat;
  logic [7:0]  r_wait;
  logic [95:0] r_line;
  logic [127:0] r_insn;
  logic [127:0] r_data;

  logic w_store_ok;
  logic w_last_beat;
  logic w_timeout;

  always_comb begin
    w_store_ok = 1'b0;
    case (i_ctrl)
      3'd0:    w_store_ok = 1'b1;
      3'd1:    w_store_ok = ~i_daddr[0];
      3'd2:    w_store_ok = (i_daddr[1:0] == 2'b00);
      default: w_store_ok = 1'b0;
    endcase
  end

  assign w_last_beat = (r_beat == 2'(LINE_BEATS - 1));
  // Counter would reach the limit at this edge: abandon the beat instead.
  assign w_timeout   = ~i_mem_ack && (r_wait == 8'(MEM_LAT_MAX - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          case (i_mode)
            3'd1, 3'd2: w_next = S_READ;
            3'd3:       w_next = w_store_ok ? S_WRITE : S_ERR;
            default:    w_next = S_ERR;
          endcase
        end
      end
      S_READ: begin
        if (i_mem_ack && w_last_beat) w_next = S_DONE;
        else if (w_timeout)           w_next = S_ERR;
      end
      S_WRITE: begin
        if (i_mem_ack)      w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_wstrb = 4'h0;
    case (r_state)
      S_READ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_addr[31:4], r_beat, 2'b00};
      end
      S_WRITE: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = {r_addr[31:2], 2'b00};
        case (r_ctrl)
          2'd0: begin
            o_mem_wdata = {4{r_wdata[7:0]}};
            o_mem_wstrb = 4'b0001 << r_addr[1:0];
          end
          2'd1: begin
            o_mem_wdata = {2{r_wdata[15:0]}};
            o_mem_wstrb = 4'b0011 << r_addr[1:0];
          end
          default: begin
            o_mem_wdata = r_wdata;
            o_mem_wstrb = 4'b1111;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERR);
  assign o_insn_data = r_insn;
  assign o_data_data = r_data;
  assign o_state     = r_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_ctrl  <= 2'd0;
      r_beat  <= 2'd0;
      r_wait  <= 8'd0;
      r_line  <= 96'h0;
      r_insn  <= 128'h0;
      r_data  <= 128'h0;
    end else begin
      if (r_state == S_IDLE && i_req) begin
        r_fetch <= (i_mode == 3'd1);
        r_addr  <= (i_mode == 3'd1) ? i_iaddr : i_daddr;
        r_wdata <= i_wdata;
        r_ctrl  <= i_ctrl[1:0];
      end

      if (o_mem_req && !i_mem_ack) r_wait <= r_wait + 8'd1;
      else                         r_wait <= 8'd0;

      if (r_state == S_READ) begin
        if (i_mem_ack) begin
          r_beat <= r_beat + 2'd1;
          case (r_beat)
            2'd0:    r_line[31:0]  <= i_mem_rdata;
            2'd1:    r_line[63:32] <= i_mem_rdata;
            2'd2:    r_line[95:64] <= i_mem_rdata;
            default: ;
          endcase
          // Only a complete line ever reaches the visible outputs.
          if (w_last_beat) begin
            if (r_fetch) r_insn <= {i_mem_rdata, r_line};
            else         r_data <= {i_mem_rdata, r_line};
          end
        end
      end else begin
        r_beat <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_cluster_mem_responder.sv
// Directed bench for cluster_mem_responder: a backend model answers beats, a
// scoreboard checks every backend beat and every done/err pulse against queued expectations.
module tb_cluster_mem_responder;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         i_req = 1'b0;
  logic [2:0]   i_mode = 3'd0;
  logic [31:0]  i_iaddr = 32'h0;
  logic [31:0]  i_daddr = 32'h0;
  logic [31:0]  i_wdata = 32'h0;
  logic [2:0]   i_ctrl = 3'd0;
  logic         o_busy, o_done, o_err;
  logic [127:0] o_insn_data, o_data_data;
  logic         o_mem_req, o_mem_we;
  logic [31:0]  o_mem_addr, o_mem_wdata;
  logic [3:0]   o_mem_wstrb;
  logic         i_mem_ack;
  logic [31:0]  i_mem_rdata;
  logic [2:0]   o_state;

  cluster_mem_responder dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_mode(i_mode), .i_iaddr(i_iaddr),
    .i_daddr(i_daddr), .i_wdata(i_wdata), .i_ctrl(i_ctrl), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_insn_data(o_insn_data),
    .o_data_data(o_data_data), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_state(o_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // {err, insn_line, data_line} expected at each done/err pulse
  logic [256:0] exp_q[$];
  // {we, addr, wdata, wstrb} expected for each new backend beat
  logic [68:0]  exp_beat_q[$];

  logic [127:0] m_insn = 128'h0;
  logic [127:0] m_data = 128'h0;

  logic [31:0] rd_vals[4];
  int stall_beat = -1;
  int stall_n = 0;
  int stall_cnt = 0;
  int hang_beat = -1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Backend model: decides ack for the beat presented in the current cycle.
  initial begin
    int idx;
    i_mem_ack = 1'b0;
    i_mem_rdata = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      i_mem_ack = 1'b0;
      i_mem_rdata = 32'h0;
      if (o_mem_req) begin
        idx = int'(o_mem_addr[3:2]);
        i_mem_rdata = rd_vals[idx];
        if (!o_mem_we && hang_beat == idx) i_mem_ack = 1'b0;
        else if (!o_mem_we && stall_beat == idx && stall_cnt < stall_n) stall_cnt++;
        else i_mem_ack = 1'b1;
      end
    end
  end

  // Monitor: backend beats and completion pulses
  logic        prev_pending = 1'b0;
  logic [68:0] prev_beat = 69'h0;
  always @(negedge CLK) begin
    logic [68:0]  cur;
    logic [256:0] e;
    if (!RST) begin
      cur = {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb};
      if (o_mem_req) begin
        if (prev_pending) begin
          chk("beat_hold", 128'(cur), 128'(prev_beat));
        end else if (exp_beat_q.size() == 0) begin
          chk("unexpected_beat", 128'(cur), 128'h0);
        end else begin
          chk("beat", 128'(cur), 128'(exp_beat_q.pop_front()));
        end
        prev_pending = ~i_mem_ack;
        prev_beat = cur;
      end else begin
        prev_pending = 1'b0;
      end
      if (o_done || o_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {126'h0, o_err, o_done}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_kind", {126'h0, o_err, o_done}, {126'h0, e[256], ~e[256]});
          chk("insn_data", o_insn_data, e[255:128]);
          chk("data_data", o_data_data, e[127:0]);
        end
      end
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic push_beat(logic we, logic [31:0] addr, logic [31:0] wd, logic [3:0] st);
    exp_beat_q.push_back({we, addr, wd, st});
  endtask

  task automatic push_resp(logic err);
    exp_q.push_back({err, m_insn, m_data});
  endtask

  task automatic set_rd(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    rd_vals[0] = a; rd_vals[1] = b; rd_vals[2] = c; rd_vals[3] = d;
  endtask

  task automatic issue(logic [2:0] mode, logic [31:0] ia, logic [31:0] da,
                       logic [31:0] wd, logic [2:0] ctrl);
    @(posedge CLK);
    #1;
    i_mode = mode; i_iaddr = ia; i_daddr = da; i_wdata = wd; i_ctrl = ctrl;
    i_req = 1'b1;
  endtask

  // Counts cycles (cycle 1 = request cycle) until a done/err pulse, bounded.
  task automatic wait_resp(int start, int limit, output int cyc);
    bit found = 0;
    cyc = start;
    while (!found && cyc < limit) begin
      @(negedge CLK);
      cyc++;
      if (o_done || o_err) found = 1;
    end
    if (!found) $display("FAIL timeout: no response within %0d cycles", limit);
  endtask

  task automatic run_req(string name, logic [2:0] mode, logic [31:0] ia, logic [31:0] da,
                         logic [31:0] wd, logic [2:0] ctrl, int exp_lat);
    int cyc;
    issue(mode, ia, da, wd, ctrl);
    @(posedge CLK);
    #1;
    i_req = 1'b0;
    wait_resp(1, exp_lat + 20, cyc);
    chk({name, "_latency"}, 128'(cyc), 128'(exp_lat));
  endtask

  task automatic check_zero(string name);
    chk({name, "_ctl"}, {123'h0, o_busy, o_done, o_err, o_mem_req, o_mem_we}, 128'h0);
    chk({name, "_mem"}, {60'h0, o_mem_addr, o_mem_wdata, o_mem_wstrb}, 128'h0);
    chk({name, "_insn"}, o_insn_data, 128'h0);
    chk({name, "_data"}, o_data_data, 128'h0);
  endtask

  initial begin
    int cyc;
    set_rd(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    chk("reset_state", 128'(o_state), 128'h0);
    RST = 1'b0;

    // Fetch of a full line, zero-wait acks
    set_rd(32'h11, 32'h22, 32'h33, 32'h44);
    push_beat(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    push_beat(1'b0, 32'h8000_0014, 32'h0, 4'h0);
    push_beat(1'b0, 32'h8000_0018, 32'h0, 4'h0);
    push_beat(1'b0, 32'h8000_001C, 32'h0, 4'h0);
    m_insn = 128'h00000044_00000033_00000022_00000011;
    push_resp(1'b0);
    run_req("fetch", 3'd1, 32'h8000_0014, 32'h0, 32'h0, 3'd0, 6);

    // Stores
    push_beat(1'b1, 32'h100, 32'hA5A5_A5A5, 4'b1000);
    push_resp(1'b0);
    run_req("st_byte", 3'd3, 32'h0, 32'h103, 32'hA5, 3'd0, 3);
    push_beat(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b1111);
    push_resp(1'b0);
    run_req("st_word", 3'd3, 32'h0, 32'h200, 32'hDEAD_BEEF, 3'd2, 3);
    push_beat(1'b1, 32'h200, 32'h1234_1234, 4'b1100);
    push_resp(1'b0);
    run_req("st_half", 3'd3, 32'h0, 32'h202, 32'h0000_1234, 3'd1, 3);

    // Rejected requests: no backend beat expected
    push_resp(1'b1);
    run_req("st_half_mis", 3'd3, 32'h0, 32'h101, 32'h1234, 3'd1, 2);
    push_resp(1'b1);
    run_req("st_word_mis", 3'd3, 32'h0, 32'h206, 32'h1234, 3'd2, 2);
    push_resp(1'b1);
    run_req("st_bad_ctrl", 3'd3, 32'h0, 32'h200, 32'h1234, 3'd3, 2);
    push_resp(1'b1);
    run_req("mode0", 3'd0, 32'h0, 32'h200, 32'h0, 3'd0, 2);
    push_resp(1'b1);
    run_req("mode7", 3'd7, 32'h0, 32'h200, 32'h0, 3'd0, 2);

    // Load with 3 stall cycles on beat 2; ctrl is ignored for reads
    set_rd(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    stall_beat = 2; stall_n = 3; stall_cnt = 0;
    push_beat(1'b0, 32'h1230, 32'h0, 4'h0);
    push_beat(1'b0, 32'h1234, 32'h0, 4'h0);
    push_beat(1'b0, 32'h1238, 32'h0, 4'h0);
    push_beat(1'b0, 32'h123C, 32'h0, 4'h0);
    m_data = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    push_resp(1'b0);
    run_req("load_stall", 3'd2, 32'h0, 32'h1238, 32'h0, 3'd7, 9);
    stall_beat = -1;

    // Load that never gets beat 2 acked: timeout, lines unchanged
    set_rd(32'h9, 32'h8, 32'h7, 32'h6);
    hang_beat = 2;
    push_beat(1'b0, 32'h40, 32'h0, 4'h0);
    push_beat(1'b0, 32'h44, 32'h0, 4'h0);
    push_beat(1'b0, 32'h48, 32'h0, 4'h0);
    push_resp(1'b1);
    run_req("load_timeout", 3'd2, 32'h0, 32'h4C, 32'h0, 3'd0, 259);
    hang_beat = -1;

    // Request during busy is ignored
    set_rd(32'h1, 32'h2, 32'h3, 32'h4);
    push_beat(1'b0, 32'h2000, 32'h0, 4'h0);
    push_beat(1'b0, 32'h2004, 32'h0, 4'h0);
    push_beat(1'b0, 32'h2008, 32'h0, 4'h0);
    push_beat(1'b0, 32'h200C, 32'h0, 4'h0);
    m_insn = 128'h00000004_00000003_00000002_00000001;
    push_resp(1'b0);
    issue(3'd1, 32'h2000, 32'h0, 32'h0, 3'd0);
    @(posedge CLK); #1; i_req = 1'b0;
    @(posedge CLK); #1;
    i_mode = 3'd3; i_daddr = 32'h300; i_wdata = 32'h5555_5555; i_ctrl = 3'd2; i_req = 1'b1;
    @(posedge CLK); #1; i_req = 1'b0;
    wait_resp(3, 30, cyc);
    chk("busy_ignore_latency", 128'(cyc), 128'd6);
    repeat (4) @(posedge CLK);

    // Reset in the middle of a load
    push_beat(1'b0, 32'h3000, 32'h0, 4'h0);
    issue(3'd2, 32'h0, 32'h3000, 32'h0, 3'd0);
    @(posedge CLK); #1; i_req = 1'b0;
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    exp_beat_q.delete();
    m_insn = 128'h0;
    m_data = 128'h0;
    @(posedge CLK); #1;
    RST = 1'b0;

    set_rd(32'h5, 32'h6, 32'h7, 32'h8);
    push_beat(1'b0, 32'h50, 32'h0, 4'h0);
    push_beat(1'b0, 32'h54, 32'h0, 4'h0);
    push_beat(1'b0, 32'h58, 32'h0, 4'h0);
    push_beat(1'b0, 32'h5C, 32'h0, 4'h0);
    m_data = 128'h00000008_00000007_00000006_00000005;
    push_resp(1'b0);
    run_req("post_reset_load", 3'd2, 32'h0, 32'h50, 32'h0, 3'd0, 6);

    repeat (5) @(posedge CLK);
    #1;
    chk("resp_queue_drained", 128'(exp_q.size()), 128'h0);
    chk("beat_queue_drained", 128'(exp_beat_q.size()), 128'h0);
    chk("idle_at_end", {127'h0, o_busy}, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
